// File: rtl/hash_scorer.sv
// Serial Hamming-distance scorer: compares each finalized hash against a target CHUNK_W bits
// per cycle and tracks the best (lowest) score. Optional threshold port: HASH_SCORER_THRESHOLD_EN.
module hash_scorer #(
  parameter int HASH_W  = 1024,
  parameter int CHUNK_W = 64,
  parameter int CAND_W  = 128,
  parameter int SCORE_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hash_valid_i,
  input  logic [HASH_W-1:0]  hash_i,
  input  logic [CAND_W-1:0]  candidate_i,
  input  logic [HASH_W-1:0]  target_i,
  output logic               busy_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               score_valid_o,
  output logic               new_best_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic [CAND_W-1:0]  best_candidate_o,
  output logic [31:0]        hashes_scored_o,
  output logic               dropped_o
`ifdef HASH_SCORER_THRESHOLD_EN
  ,
  input  logic [SCORE_W-1:0] threshold_i,
  output logic               found_o
`endif
);

  localparam int NCHUNK = HASH_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCORE,
    S_DONE
  } state_t;

  state_t             state;
  logic [HASH_W-1:0]  diff_reg;
  logic [CAND_W-1:0]  cand_reg;
  logic [SCORE_W-1:0] acc;
  logic [CNT_W-1:0]   chunk;
  logic [SCORE_W-1:0] sum_next;

  function automatic logic [SCORE_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [SCORE_W-1:0] n;
    // NOTE: blocking assignments are right here: n is a function-local temporary, not state.
    n = '0;
    for (int i = 0; i < CHUNK_W; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

  assign sum_next = acc + popcount(diff_reg[CHUNK_W-1:0]);
  assign busy_o   = (state != S_IDLE);

  // NOTE: datapath registers carry no reset; control state decides when their contents matter.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && hash_valid_i) begin
      diff_reg <= hash_i ^ target_i;
      cand_reg <= candidate_i;
      acc      <= '0;
      chunk    <= '0;
    end else if (state == S_SCORE) begin
      diff_reg <= diff_reg >> CHUNK_W;
      acc      <= sum_next;
      chunk    <= chunk + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      score_o          <= '0;
      score_valid_o    <= 1'b0;
      new_best_o       <= 1'b0;
      best_score_o     <= '1;
      best_candidate_o <= '0;
      hashes_scored_o  <= '0;
      dropped_o        <= 1'b0;
`ifdef HASH_SCORER_THRESHOLD_EN
      found_o          <= 1'b0;
`endif
    end else begin
      score_valid_o <= 1'b0;
      new_best_o    <= 1'b0;
      if (hash_valid_i && state != S_IDLE) dropped_o <= 1'b1;

      case (state)
        S_IDLE: begin
          if (hash_valid_i) state <= S_SCORE;
        end
        S_SCORE: begin
          if (chunk == LAST_CHUNK) begin
            score_o       <= sum_next;
            score_valid_o <= 1'b1;
            new_best_o    <= (sum_next < best_score_o);
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          hashes_scored_o <= hashes_scored_o + 32'd1;
          // Strict compare was taken above, so ties keep the earlier candidate.
          if (new_best_o) begin
            best_score_o     <= score_o;
            best_candidate_o <= cand_reg;
          end
`ifdef HASH_SCORER_THRESHOLD_EN
          if (score_o <= threshold_i) found_o <= 1'b1;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_scorer.sv
// Directed self-checking bench for hash_scorer; threshold test runs when
// HASH_SCORER_THRESHOLD_EN is defined.
module tb_hash_scorer;

  localparam int HASH_W  = 1024;
  localparam int CAND_W  = 128;
  localparam int SCORE_W = 11;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               hash_valid_i = 1'b0;
  logic [HASH_W-1:0]  hash_i = '0;
  logic [CAND_W-1:0]  candidate_i = '0;
  logic [HASH_W-1:0]  target_i;
  logic               busy_o;
  logic [SCORE_W-1:0] score_o;
  logic               score_valid_o;
  logic               new_best_o;
  logic [SCORE_W-1:0] best_score_o;
  logic [CAND_W-1:0]  best_candidate_o;
  logic [31:0]        hashes_scored_o;
  logic               dropped_o;
`ifdef HASH_SCORER_THRESHOLD_EN
  logic [SCORE_W-1:0] threshold_i = 11'd10;
  logic               found_o;
`endif

  int total = 0;
  int bad   = 0;

  hash_scorer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .hash_valid_i     (hash_valid_i),
    .hash_i           (hash_i),
    .candidate_i      (candidate_i),
    .target_i         (target_i),
    .busy_o           (busy_o),
    .score_o          (score_o),
    .score_valid_o    (score_valid_o),
    .new_best_o       (new_best_o),
    .best_score_o     (best_score_o),
    .best_candidate_o (best_candidate_o),
    .hashes_scored_o  (hashes_scored_o),
    .dropped_o        (dropped_o)
`ifdef HASH_SCORER_THRESHOLD_EN
    ,
    .threshold_i      (threshold_i),
    .found_o          (found_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [HASH_W-1:0] ones_at(input int lo, input int n);
    logic [HASH_W-1:0] m;
    m = '0;
    for (int i = lo; i < lo + n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge E0.
  task automatic send(input logic [HASH_W-1:0] h, input logic [CAND_W-1:0] c);
    @(negedge clk_i);
    hash_i       = h;
    candidate_i  = c;
    hash_valid_i = 1'b1;
    @(negedge clk_i);
    hash_valid_i = 1'b0;
  endtask

  // Counts edges after E0 until score_valid_o is seen; leaves the bench in the DONE cycle.
  task automatic wait_score(input string tag);
    int lat;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (score_valid_o) break;
    end
    check({tag, "_latency"}, 128'(lat), 128'd16);
  endtask

  // Waits through the edge ending DONE and samples just after it.
  task automatic finish_done();
    @(posedge clk_i);
    #1;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      if (score_valid_o) pulses++;
    end
  endtask

  initial begin
    int pulses;
    target_i = {16{64'h0123_4567_89AB_CDEF}};

    // 1: exact match
    do_reset();
    #1;
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_score", 128'(score_o), 128'd0);
    check("rst_valid", 128'(score_valid_o), 128'd0);
    check("rst_new_best", 128'(new_best_o), 128'd0);
    check("rst_best_score", 128'(best_score_o), 128'd2047);
    check("rst_best_cand", 128'(best_candidate_o), 128'd0);
    check("rst_count", 128'(hashes_scored_o), 128'd0);
    check("rst_dropped", 128'(dropped_o), 128'd0);
    send(target_i, 128'hA5);
    check("t1_busy", 128'(busy_o), 128'd1);
    wait_score("t1");
    check("t1_score", 128'(score_o), 128'd0);
    check("t1_new_best", 128'(new_best_o), 128'd1);
    finish_done();
    check("t1_valid_off", 128'(score_valid_o), 128'd0);
    check("t1_best_score", 128'(best_score_o), 128'd0);
    check("t1_best_cand", 128'(best_candidate_o), 128'hA5);
    check("t1_count", 128'(hashes_scored_o), 128'd1);
    check("t1_idle", 128'(busy_o), 128'd0);

    // 2: all bits differ
    do_reset();
    send(~target_i, 128'h2);
    wait_score("t2");
    check("t2_score", 128'(score_o), 128'd1024);
    check("t2_new_best", 128'(new_best_o), 128'd1);
    finish_done();
    check("t2_best_score", 128'(best_score_o), 128'd1024);
    check("t2_best_cand", 128'(best_candidate_o), 128'h2);

    // 3: tie keeps earlier candidate; second strobe lands the cycle IDLE is re-entered
    do_reset();
    send(target_i ^ ones_at(0, 400), 128'h1);
    wait_score("t3a");
    check("t3a_score", 128'(score_o), 128'd400);
    check("t3a_new_best", 128'(new_best_o), 128'd1);
    finish_done();
    send(target_i ^ ones_at(500, 400), 128'h2);
    wait_score("t3b");
    check("t3b_score", 128'(score_o), 128'd400);
    check("t3b_new_best", 128'(new_best_o), 128'd0);
    finish_done();
    check("t3_best_cand", 128'(best_candidate_o), 128'h1);
    check("t3_best_score", 128'(best_score_o), 128'd400);
    check("t3_count", 128'(hashes_scored_o), 128'd2);
    check("t3_dropped", 128'(dropped_o), 128'd0);

    // 4: strobe while busy is dropped
    do_reset();
    send(target_i ^ ones_at(100, 3), 128'h7);
    repeat (3) @(negedge clk_i);
    hash_i       = ~target_i;
    candidate_i  = 128'h8;
    hash_valid_i = 1'b1;
    @(negedge clk_i);
    hash_valid_i = 1'b0;
    count_pulses(40, pulses);
    check("t4_pulses", 128'(pulses), 128'd1);
    check("t4_dropped", 128'(dropped_o), 128'd1);
    check("t4_count", 128'(hashes_scored_o), 128'd1);
    check("t4_score", 128'(score_o), 128'd3);
    check("t4_best_cand", 128'(best_candidate_o), 128'h7);

    // 5: reset mid-score at chunk 7
    do_reset();
    send(~target_i, 128'h9);
    repeat (7) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("t5_busy", 128'(busy_o), 128'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    count_pulses(30, pulses);
    check("t5_pulses", 128'(pulses), 128'd0);
    check("t5_best_score", 128'(best_score_o), 128'd2047);
    check("t5_count", 128'(hashes_scored_o), 128'd0);

`ifdef HASH_SCORER_THRESHOLD_EN
    // 6: sticky threshold hit
    do_reset();
    send(target_i ^ ones_at(0, 11), 128'h11);
    wait_score("t6a");
    finish_done();
    check("t6a_found", 128'(found_o), 128'd0);
    send(target_i ^ ones_at(0, 10), 128'h12);
    wait_score("t6b");
    finish_done();
    check("t6b_found", 128'(found_o), 128'd1);
    send(target_i ^ ones_at(0, 900), 128'h13);
    wait_score("t6c");
    check("t6c_score", 128'(score_o), 128'd900);
    finish_done();
    check("t6c_found", 128'(found_o), 128'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
